uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os -- oversampling UART receiver with majority-vote bit recovery.
//
// Receives 8N1 frames (or 8E1/8O1 when PARITY_EN=1) on an asynchronous serial
// line. The line is brought into the clock domain by a 2-flop synchronizer and
// every bit is recovered as the majority of three samples taken around the
// bit centre (M-D, M, M+D clocks into the bit, M = CLKS_PER_BIT/2,
// D = CLKS_PER_BIT/8).
//
// Parameters
//   CLKS_PER_BIT : clocks per bit period (16 or more)
//   PARITY_EN    : 1 = one parity bit follows the data bits
//   PARITY_ODD   : 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//
// Ports
//   i_clk        : single clock
//   i_rst        : synchronous, active-high reset
//   i_rx_serial  : asynchronous serial input, idle high
//   o_rx_dv      : one-cycle pulse, good frame received, o_rx_byte valid
//   o_rx_byte    : last received data byte (LSB first on the line)
//   o_parity_err : one-cycle pulse, parity mismatch (stop bit was good)
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_break      : one-cycle pulse with o_frame_err when the whole frame was 0
//   o_rx_active  : high whenever the receiver FSM is not in IDLE
//
// Output timing: the stop bit is judged M+D clocks into the stop bit; all
// result pulses and the o_rx_byte update are registered and appear on the
// following cycle. The receiver is back in IDLE before the stop bit ends, so
// a start bit that immediately follows the stop bit is not missed.
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_rx_active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int M     = CLKS_PER_BIT / 2;
  localparam int D     = CLKS_PER_BIT / 8;

  // Sample points within a bit and the last count of a bit period.
  localparam logic [CNT_W-1:0] SMP_EARLY = CNT_W'(M - D);
  localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(M);
  localparam logic [CNT_W-1:0] SMP_LATE  = CNT_W'(M + D);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rx_meta_q, rx_meta_d;   // synchronizer stage 1
  logic             rx_s_q,    rx_s_d;      // synchronizer stage 2 (rx_s)
  logic [1:0]       sync_vld_q, sync_vld_d; // rx_s carries a real line sample
  logic             rx_prev_q, rx_prev_d;   // rx_s one cycle ago (edge detect)
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       smp_q,     smp_d;       // early and mid samples of a bit
  logic [2:0]       idx_q,     idx_d;       // data bit index
  logic [7:0]       shift_q,   shift_d;
  logic             par_q,     par_d;       // received parity bit
  logic [7:0]       byte_q,    byte_d;
  logic             dv_q,      dv_d;
  logic             perr_q,    perr_d;
  logic             ferr_q,    ferr_d;
  logic             brk_q,     brk_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic vote;       // majority of early, mid and the current (late) sample
  logic fall;       // falling edge of rx_s
  logic par_bad;    // received parity does not match the configured sense
  logic all_zero;   // data and parity bits were all 0

  always_comb begin
    vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    fall     = rx_prev_q & ~rx_s_q;
    par_bad  = (PARITY_EN != 0) && ((^{shift_q, par_q}) != (PARITY_ODD != 0));
    all_zero = (shift_q == 8'h00) && ((PARITY_EN == 0) || !par_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_meta_d  = i_rx_serial;
    rx_s_d     = rx_meta_q;
    // The synchronizer is preset to 1 by reset; those forced ones must not be
    // mistaken for an idle line, otherwise a line already low when reset
    // releases (frame in progress) would look like a fresh falling edge.
    // The edge detector is therefore only fed once both stages hold real
    // line samples.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    rx_prev_d  = sync_vld_q[1] & rx_s_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;

    // Bit timing runs in every state that is inside a frame.
    if ((state_q == START) || (state_q == DATA) ||
        (state_q == PARITY) || (state_q == STOP)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SMP_EARLY) smp_d[0] = rx_s_q;
      if (cnt_q == SMP_MID)   smp_d[1] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      end

      START: begin
        if ((cnt_q == SMP_LATE) && vote) begin
          // Start bit did not hold low: treat as noise, no outputs.
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        if (cnt_q == SMP_LATE) shift_d = {vote, shift_q[7:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (cnt_q == SMP_LATE) par_d = vote;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end

      STOP: begin
        // Judged mid-stop-bit so the receiver is idle again before the next
        // start bit can begin.
        if (cnt_q == SMP_LATE) begin
          byte_d = shift_q;
          if (vote) begin
            if (par_bad) perr_d = 1'b1;
            else         dv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = all_zero;
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // Only a high line releases the receiver; low levels and edges here
        // belong to the broken frame or the break.
        if (rx_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= 2'b00;
      rx_prev_q  <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      smp_q      <= 2'b00;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      byte_q     <= 8'h00;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      sync_vld_q <= sync_vld_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      byte_q     <= byte_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign o_rx_dv      = dv_q;
  assign o_rx_byte    = byte_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_rx_active  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os -- self-checking bench for uart_rx_os at CLKS_PER_BIT=16.
// dut0: no parity. dut1: odd parity. Each has its own serial line.
// Every output event (any pulse high) is packed as {dv, perr, ferr, brk, byte}
// and compared against an expected queue filled when the frame is driven.
// The byte field is not compared on frame errors.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int CPB = 16;
  localparam int W   = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       dv0, pe0, fe0, bk0, ra0;
  logic [7:0] byte0;
  logic       dv1, pe1, fe1, bk1, ra1;
  logic [7:0] byte1;

  uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx0),
    .o_rx_dv(dv0), .o_rx_byte(byte0), .o_parity_err(pe0),
    .o_frame_err(fe0), .o_break(bk0), .o_rx_active(ra0)
  );

  uart_rx_os #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial(rx1),
    .o_rx_dv(dv1), .o_rx_byte(byte1), .o_parity_err(pe1),
    .o_frame_err(fe1), .o_break(bk1), .o_rx_active(ra1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int last_evt0_cyc = 0;
  int start0_cyc    = 0;

  function automatic logic [W-1:0] evt(input logic dv, input logic pe,
                                       input logic fe, input logic bk,
                                       input logic [7:0] b);
    return {dv, pe, fe, bk, (fe ? 8'h00 : b)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dv0 | pe0 | fe0 | bk0) begin
        last_evt0_cyc = cyc;
        if (exp0_q.size() == 0) chk("dut0 unexpected event", evt(dv0, pe0, fe0, bk0, byte0), 0);
        else                    chk("dut0 event", evt(dv0, pe0, fe0, bk0, byte0), exp0_q.pop_front());
      end
      if (dv1 | pe1 | fe1 | bk1) begin
        if (exp1_q.size() == 0) chk("dut1 unexpected event", evt(dv1, pe1, fe1, bk1, byte1), 0);
        else                    chk("dut1 event", evt(dv1, pe1, fe1, bk1, byte1), exp1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one clock of line level, changed 1 time unit after the edge.
  task automatic drive(input int which, input logic v);
    @(posedge clk); #1;
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic idle(input int which, input int n);
    repeat (n) drive(which, 1'b1);
  endtask

  // glitch_bit: frame bit (0 = start) whose 10th clock is inverted, -1 none.
  // rst_bit: frame bit during which reset pulses for 3 clocks, -1 none.
  task automatic send_frame(input int which, input logic [7:0] data,
                            input bit par_en, input bit par_val, input bit stop_val,
                            input int glitch_bit, input int rst_bit);
    logic bits[11];
    int   nb;
    logic v;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1+j] = data[j];
    nb = 9;
    if (par_en) begin
      bits[9] = par_val;
      nb = 10;
    end
    bits[nb] = stop_val;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        v = bits[b];
        if (b == glitch_bit && c == 9) v = ~v;
        @(posedge clk); #1;
        if (b == 0 && c == 0 && which == 0) start0_cyc = cyc;
        if (b == rst_bit && c == 4) rst = 1'b1;
        if (b == rst_bit && c == 6)
          chk("outputs in reset", {19'd0, dv1, pe1, fe1, bk1, ra1, byte1}, 0);
        if (b == rst_bit && c == 7) rst = 1'b0;
        if (which == 0) rx0 = v;
        else            rx1 = v;
      end
    end
  endtask

  task automatic wait_drain(input int which, input int budget);
    int k = 0;
    while (((which == 0) ? exp0_q.size() : exp1_q.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pending expected events", (which == 0) ? exp0_q.size() : exp1_q.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]   data;
    bit           stop;
    int           glitch;
    int           gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t0;
    logic [7:0] r;

    tbl[0] = '{8'hA5, 1'b1, -1, 20, evt(1, 0, 0, 0, 8'hA5)};
    tbl[1] = '{8'h00, 1'b1,  3, 20, evt(1, 0, 0, 0, 8'h00)};  // glitch in data bit 2
    tbl[2] = '{8'hFF, 1'b1, -1,  0, evt(1, 0, 0, 0, 8'hFF)};  // back-to-back with next
    tbl[3] = '{8'h55, 1'b1, -1, 20, evt(1, 0, 0, 0, 8'h55)};
    tbl[4] = '{8'h81, 1'b0, -1,  8, evt(0, 0, 1, 0, 8'h81)};  // bad stop, not a break
    for (int i = 5; i < 8; i++) begin
      r = 8'($urandom_range(0, 255));
      tbl[i] = '{r, 1'b1, -1, $urandom_range(0, 10), evt(1, 0, 0, 0, r)};
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("dut0 reset outputs", {19'd0, dv0, pe0, fe0, bk0, ra0, byte0}, 0);
    chk("dut1 reset outputs", {19'd0, dv1, pe1, fe1, bk1, ra1, byte1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0, 10);

    // table-driven frames on dut0
    for (int i = 0; i < 8; i++) begin
      exp0_q.push_back(tbl[i].exp);
      send_frame(0, tbl[i].data, 0, 0, tbl[i].stop, tbl[i].glitch, -1);
      idle(0, tbl[i].gap);
      if (i == 0) begin
        wait_drain(0, 50);
        // 2 sync + 1 edge detect + 9 bit periods + M+D + 1 register
        chk("line-to-dv latency", last_evt0_cyc - start0_cyc, 158);
      end
    end
    idle(0, 10);
    wait_drain(0, 200);

    // false start: low for 3 clocks
    drive(0, 1'b0);
    t0 = cyc;
    drive(0, 1'b0);
    drive(0, 1'b0);
    drive(0, 1'b1);
    wait_cyc(t0 + 13);
    chk("active at START cnt=10", ra0, 1);
    wait_cyc(t0 + 14);
    chk("active at START cnt=11", ra0, 0);
    idle(0, 20);

    // frame 0x3C with stop low, line held low afterwards
    exp0_q.push_back(evt(0, 0, 1, 0, 8'h3C));
    send_frame(0, 8'h3C, 0, 0, 0, -1, -1);
    repeat (30) drive(0, 1'b0);
    chk("active in WAIT_IDLE", ra0, 1);
    idle(0, 20);
    chk("active after line idle", ra0, 0);
    wait_drain(0, 10);
    exp0_q.push_back(evt(1, 0, 0, 0, 8'h3C));
    send_frame(0, 8'h3C, 0, 0, 1, -1, -1);
    idle(0, 20);
    wait_drain(0, 50);

    // break: 12 bit periods low, then a normal frame
    exp0_q.push_back(evt(0, 0, 1, 1, 8'h00));
    repeat (12 * CPB) drive(0, 1'b0);
    idle(0, 20);
    exp0_q.push_back(evt(1, 0, 0, 0, 8'h55));
    send_frame(0, 8'h55, 0, 0, 1, -1, -1);
    idle(0, 20);
    wait_drain(0, 50);

    // odd parity on dut1
    exp1_q.push_back(evt(1, 0, 0, 0, 8'h01));
    send_frame(1, 8'h01, 1, 0, 1, -1, -1);  // one 1 in data, parity 0: odd, good
    idle(1, 20);
    exp1_q.push_back(evt(0, 1, 0, 0, 8'h01));
    send_frame(1, 8'h01, 1, 1, 1, -1, -1);  // two 1s total: parity error
    idle(1, 20);
    wait_drain(1, 50);
    chk("byte after parity error", byte1, 8'h01);

    // reset during data bit 3 of a frame; rest of that frame must be ignored
    send_frame(1, 8'h00, 1, 1, 1, -1, 4);
    idle(1, 30);
    chk("byte after mid-frame reset", byte1, 8'h00);
    chk("active after mid-frame reset", ra1, 0);
    wait_drain(1, 10);
    exp1_q.push_back(evt(1, 0, 0, 0, 8'h80));
    send_frame(1, 8'h80, 1, 0, 1, -1, -1);
    idle(1, 20);
    wait_drain(1, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
